imm_ext_pipe: RTL and testbench

Pipelined, parametrised immediate extractor for the LEGv8 datapath. Accepts 32-bit instruction words over a valid/ready handshake and decodes each one's immediate field: D, CB, B, I and IW (MOVZ) formats. Produces an XLEN-wide extended immediate plus a format tag and an illegal flag one cycle later through a 2-entry skid buffer. Sits between fetch/decode and the register-read stage, replacing the single-cycle combinational sign extender.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_ext_pipe_decode.sv | 28 ++
 rtl/imm_ext_pipe.sv | 47 ++++
 tb/tb_imm_ext_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: format tags, LEGv8 opcode constants and the decoded entry type for imm_ext_pipe.
package imm_pkg;
   typedef enum logic [2:0] {NONE = 3'd0, D = 3'd1, CB = 3'd2, B = 3'd3, I = 3'd4, IW = 3'd5} fmt_e;
   localparam int MAX_XLEN = 64;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [5:0]  OP_BL   = 6'b100101;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [8:0]  OP_MOVZ = 9'b110100101;
   // imm is held at the widest legal XLEN; the top truncates to its own XLEN
   typedef struct packed {
      logic [MAX_XLEN-1:0] imm;
      fmt_e                fmt;
      logic                illegal;
   } entry_t;
endpackage

// File: rtl/imm_ext_pipe_decode.sv
// imm_decode: combinational LEGv8 immediate decoder, first matching format wins.
// IMM_BRANCH_SHL2_EN turns CB/B word offsets into byte offsets.
module imm_decode
   import imm_pkg::*;
(
   input  logic [31:0] instr,
   output entry_t      e
);
`ifdef IMM_BRANCH_SHL2_EN
   localparam int BR_SH = 2;
`else
   localparam int BR_SH = 0;
`endif
   logic [63:0] sd, scb, sb, zi, ziw;
   assign sd  = {{55{instr[20]}}, instr[20:12]};
   assign scb = {{45{instr[23]}}, instr[23:5]} << BR_SH;
   assign sb  = {{38{instr[25]}}, instr[25:0]} << BR_SH;
   assign zi  = {52'b0, instr[21:10]};
   assign ziw = {48'b0, instr[20:5]} << {instr[22:21], 4'b0};
   always_comb begin
      e = '{imm: '0, fmt: NONE, illegal: 1'b1};
      if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) e = '{imm: sd, fmt: D, illegal: 1'b0};
      else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) e = '{imm: scb, fmt: CB, illegal: 1'b0};
      else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) e = '{imm: sb, fmt: B, illegal: 1'b0};
      else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) e = '{imm: zi, fmt: I, illegal: 1'b0};
      else if (instr[31:23] == OP_MOVZ) e = '{imm: ziw, fmt: IW, illegal: 1'b0};
   end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extractor behind a 2-entry skid buffer with a
// saturating illegal-word counter. Honours IMM_BRANCH_SHL2_EN via imm_decode.
module imm_ext_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output fmt_e             out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);
   entry_t d, head, tail;
   logic [1:0] cnt;
   logic push, pop;
   imm_decode u_dec (.instr(in_instr), .e(d));
   // ready depends only on registered occupancy, never on out_ready
   assign in_ready    = cnt != 2'd2;
   assign out_valid   = cnt != 2'd0;
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign out_imm     = head.imm[XLEN-1:0];
   assign out_fmt     = head.fmt;
   assign out_illegal = head.illegal;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head          <= '0;
         tail          <= '0;
         cnt           <= 2'd0;
         illegal_count <= '0;
      end else begin
         if (push && (cnt == 2'd0 || pop)) head <= d;
         else if (pop && cnt == 2'd2) head <= tail;
         if (push && cnt == 2'd1 && !pop) tail <= d;
         cnt <= cnt + 2'(push) - 2'(pop);
         if (push && d.illegal && illegal_count != '1) illegal_count <= illegal_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed literal checks plus randomized traffic against a queue-based model.
module tb_imm_ext_pipe;
   logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_instr = 0;
   logic in_ready, out_valid, out_illegal, in_ready2, out_valid2, out_illegal2;
   logic [63:0] out_imm;
   logic [31:0] out_imm2;
   logic [2:0] out_fmt, out_fmt2;
   logic [15:0] illegal_count;
   logic [1:0] illegal_count2;
   int total = 0, bad = 0;
   typedef struct {logic [63:0] imm; int fmt; bit ill;} exp_t;
   exp_t q[$];
   int mcnt = 0;
`ifdef IMM_BRANCH_SHL2_EN
   localparam longint BR_MUL = 4;
`else
   localparam longint BR_MUL = 1;
`endif
   localparam logic [31:0] W_LDUR = 32'hF85F8000, W_CBZ = 32'hB4FFFFE0, W_B = 32'h14000010,
                           W_ADDI = 32'h913FFC00, W_MOVZ = 32'hD2E24680;

   imm_ext_pipe dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_count(illegal_count));
   imm_ext_pipe #(.XLEN(32), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .in_valid(in_valid),
      .in_ready(in_ready2), .in_instr(in_instr), .out_valid(out_valid2), .out_ready(out_ready),
      .out_imm(out_imm2), .out_fmt(out_fmt2), .out_illegal(out_illegal2), .illegal_count(illegal_count2));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      return ((v >> (w - 1)) & 1) != 0 ? v - (longint'(1) << w) : v;
   endfunction

   function automatic exp_t ref_dec(input logic [31:0] w);
      exp_t r;
      r.ill = 0;
      if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
         r.fmt = 1; r.imm = sx(longint'(w[20:12]), 9);
      end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
         r.fmt = 2; r.imm = sx(longint'(w[23:5]), 19) * BR_MUL;
      end else if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
         r.fmt = 3; r.imm = sx(longint'(w[25:0]), 26) * BR_MUL;
      end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
         r.fmt = 4; r.imm = longint'(w[21:10]);
      end else if (w[31:23] == 9'b110100101) begin
         r.fmt = 5; r.imm = longint'(w[20:5]) << (16 * int'(w[22:21]));
      end else begin
         r.fmt = 0; r.imm = 0; r.ill = 1;
      end
      return r;
   endfunction

   always @(negedge reset) begin
      q.delete();
      mcnt = 0;
   end

   always @(posedge clk) if (reset) begin
      bit push, pop;
      exp_t e;
      push = in_valid && q.size() < 2;
      pop = q.size() > 0 && out_ready;
      e = ref_dec(in_instr);
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back(e);
         if (e.ill && mcnt < 65535) mcnt++;
      end
   end

   always @(negedge clk) if (reset) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("count", 64'(illegal_count), 64'(mcnt));
      chk("count_sat", 64'(illegal_count2), 64'(mcnt > 3 ? 3 : mcnt));
      chk("out_valid2", 64'(out_valid2), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("imm", out_imm, q[0].imm);
         chk("fmt", 64'(out_fmt), 64'(q[0].fmt));
         chk("illegal", 64'(out_illegal), 64'(q[0].ill));
         chk("imm32", 64'(out_imm2), 64'(q[0].imm[31:0]));
      end
   end

   task automatic cyc(input bit v, input logic [31:0] w, input bit r);
      in_valid = v;
      in_instr = w;
      out_ready = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 10))
         0: return {11'b11111000010, r[20:0]};
         1: return {11'b11111000000, r[20:0]};
         2: return {8'b10110100, r[23:0]};
         3: return {8'b10110101, r[23:0]};
         4: return {6'b000101, r[25:0]};
         5: return {6'b100101, r[25:0]};
         6: return {10'b1001000100, r[21:0]};
         7: return {10'b1101000100, r[21:0]};
         8: return {9'b110100101, r[22:0]};
         9: return 32'h0;
         default: return r;
      endcase
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_imm", out_imm, 64'd0);
      chk("rst_fmt", 64'(out_fmt), 64'd0);
      chk("rst_illegal", 64'(out_illegal), 64'd0);
      chk("rst_count", 64'(illegal_count), 64'd0);
      #2 reset = 1;
      @(negedge clk);
      repeat (3) cyc(1, 32'h0, 1);
      chk("ill_flag", 64'(out_illegal), 64'd1);
      chk("ill_imm", out_imm, 64'd0);
      chk("ill_count3", 64'(illegal_count), 64'd3);
      repeat (2) cyc(1, 32'h0, 1);
      chk("ill_count5", 64'(illegal_count), 64'd5);
      chk("ill_sat", 64'(illegal_count2), 64'd3);
      cyc(1, W_LDUR, 1);
      chk("ldur_valid", 64'(out_valid), 64'd1);
      chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("ldur_fmt", 64'(out_fmt), 64'd1);
      cyc(1, W_CBZ, 1);
      chk("cbz_imm", out_imm, 64'(-1 * BR_MUL));
      cyc(1, W_B, 1);
      chk("b_imm", out_imm, 64'(16 * BR_MUL));
      cyc(1, W_ADDI, 1);
      chk("addi_imm", out_imm, 64'h0000_0000_0000_0FFF);
      cyc(1, W_MOVZ, 1);
      chk("movz_imm", out_imm, 64'h1234_0000_0000_0000);
      chk("movz_imm32", 64'(out_imm2), 64'd0);
      cyc(0, 32'h0, 1);
      cyc(1, W_B, 0);
      chk("bp_ready1", 64'(in_ready), 64'd1);
      cyc(1, W_ADDI, 0);
      chk("bp_ready2", 64'(in_ready), 64'd0);
      cyc(1, W_LDUR, 0);
      chk("bp_head", out_imm, 64'(16 * BR_MUL));
      cyc(0, 32'h0, 1);
      chk("bp_second", out_imm, 64'h0FFF);
      cyc(0, 32'h0, 1);
      chk("bp_drained", 64'(out_valid), 64'd0);
      cyc(1, W_B, 0);
      cyc(1, W_ADDI, 0);
      #2 reset = 0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_count", 64'(illegal_count), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      #2 reset = 1;
      @(negedge clk);
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      cyc(1, W_ADDI, 1);
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_imm", out_imm, 64'h0FFF);
      for (int k = 0; k < 3000; k++)
         cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7);
      repeat (3) cyc(0, 32'h0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
